wm8731_i2c_responder: RTL

// - I2C write-only responder (slave) emulating the WM8731 control port, i.e. the far end of the codec-init I2C master.
// - Decodes 3-byte frames (device addr+W, {reg[6:0],data[8]}, data[7:0]), ACKs them and updates a 9-bit register file.
// - Used as a synthesizable codec stand-in for board bring-up and as the DUT-side partner when the initializer is simulated.

---
 rtl/wm8731_i2c_responder_pkg.sv | 28 ++
 rtl/wm8731_i2c_responder_sync.sv | 38 +++
 rtl/wm8731_i2c_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/wm8731_i2c_responder_pkg.sv
// Shared definitions for the WM8731 control-port responder: FSM states,
// the register-file reset image and the special reset-register address.
package wm8731_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV       = 4'd1,
        ST_ACK0      = 4'd2,
        ST_HI        = 4'd3,
        ST_ACK1      = 4'd4,
        ST_LO        = 4'd5,
        ST_ACK2      = 4'd6,
        ST_WAIT_STOP = 4'd7,
        ST_IGNORE    = 4'd8
    } state_t;

    localparam logic [6:0] REG_RESET = 7'h0F;

    localparam logic [8:0] REG_DEFAULTS [10] = '{
        9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
        9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
    };

    function automatic logic [8:0] reg_default(input logic [3:0] idx);
        return (idx < 4'd10) ? REG_DEFAULTS[idx] : 9'h000;
    endfunction

endpackage

// File: rtl/wm8731_i2c_responder_sync.sv
// Brings SCL/SDA into the clock domain and reports SCL edges plus bus
// START/STOP conditions as single-cycle strobes.
module i2c_bus_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda_s
);
    // [0] metastability stage, [1] synchronized level, [2] previous level
    logic [2:0] scl_q;
    logic [2:0] sda_q;
    logic [1:0] warm_q;
    logic       live;

    always_ff @(posedge i_clk) begin
        scl_q <= {scl_q[1:0], i_scl};
        sda_q <= {sda_q[1:0], i_sda};
        if (!i_rst_n) begin
            warm_q <= 2'd0;
        end else if (warm_q != 2'd3) begin
            warm_q <= warm_q + 2'd1;
        end
    end

    // Edges are suppressed until the chain holds three genuine bus samples.
    assign live       = (warm_q == 2'd3);
    assign o_sda_s    = sda_q[1];
    assign o_scl_rise = live &  scl_q[1] & ~scl_q[2];
    assign o_scl_fall = live & ~scl_q[1] &  scl_q[2];
    assign o_start    = live &  scl_q[1] & ~sda_q[1] &  sda_q[2];
    assign o_stop     = live &  scl_q[1] &  sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/wm8731_i2c_responder.sv
// WM8731 control-port emulator: write-only I2C responder with a 9-bit register
// file. Frames are {dev+W}, {reg[6:0], data[8]}, {data[7:0]}; byte three commits.
module wm8731_i2c_responder
    import wm8731_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         NUM_REGS = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oen,
    output logic       o_reg_wen,
    output logic [6:0] o_reg_addr,
    output logic [8:0] o_reg_data,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic       o_busy,
    output logic       o_frame_err
);
    logic scl_rise, scl_fall, bus_start, bus_stop, sda_s;

    i2c_bus_sync u_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_scl_rise (scl_rise),
        .o_scl_fall (scl_fall),
        .o_start    (bus_start),
        .o_stop     (bus_stop),
        .o_sda_s    (sda_s)
    );

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] hi_q, hi_d;
    logic       oen_q, oen_d;
    logic       wen_q, wen_d;
    logic       err_q, err_d;
    logic [6:0] addr_q, addr_d;
    logic [8:0] data_q, data_d;
    logic [8:0] regs_q [NUM_REGS];
    logic [8:0] regs_d [NUM_REGS];
    logic       receiving;
    logic [6:0] c_addr;
    logic [8:0] c_data;

    assign receiving = state_q inside {ST_DEV, ST_HI, ST_LO, ST_WAIT_STOP};
    assign c_addr    = hi_q[7:1];
    assign c_data    = {hi_q[0], sh_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        hi_d    = hi_q;
        oen_d   = oen_q;
        wen_d   = 1'b0;
        err_d   = err_q;
        addr_d  = addr_q;
        data_d  = data_q;
        regs_d  = regs_q;
        if (bus_stop) begin
            state_d = ST_IDLE;
            oen_d   = 1'b0;
            if (state_q inside {ST_HI, ST_ACK1, ST_LO}) err_d = 1'b1;
        end else if (bus_start) begin
            state_d = ST_DEV;
            cnt_d   = 4'd0;
            oen_d   = 1'b0;
            if (state_q inside {ST_ACK0, ST_HI, ST_ACK1, ST_LO, ST_ACK2}) err_d = 1'b1;
        end else if (scl_rise && receiving) begin
            sh_d  = {sh_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
        end else if (scl_fall) begin
            // A full byte is acted on at the SCL fall that opens its ACK slot.
            case (state_q)
                ST_DEV: if (cnt_q == 4'd8) begin
                    if (sh_q == {DEV_ADDR, 1'b0}) begin
                        state_d = ST_ACK0;
                        oen_d   = 1'b1;
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end
                ST_HI: if (cnt_q == 4'd8) begin
                    hi_d    = sh_q;
                    state_d = ST_ACK1;
                    oen_d   = 1'b1;
                end
                ST_LO: if (cnt_q == 4'd8) begin
                    state_d = ST_ACK2;
                    oen_d   = 1'b1;
                    wen_d   = 1'b1;
                    addr_d  = c_addr;
                    data_d  = c_data;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (c_addr == 7'(i)) regs_d[i] = c_data;
                        else if (c_addr == REG_RESET) regs_d[i] = reg_default(4'(i));
                    end
                end
                ST_ACK0: begin state_d = ST_HI;        oen_d = 1'b0; cnt_d = 4'd0; end
                ST_ACK1: begin state_d = ST_LO;        oen_d = 1'b0; cnt_d = 4'd0; end
                ST_ACK2: begin state_d = ST_WAIT_STOP; oen_d = 1'b0; cnt_d = 4'd0; end
                ST_WAIT_STOP: if (cnt_q == 4'd8) begin
                    err_d   = 1'b1;
                    state_d = ST_IGNORE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        sh_q <= sh_d;
        hi_q <= hi_d;
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            oen_q   <= 1'b0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 7'd0;
            data_q  <= 9'd0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reg_default(4'(i));
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oen_q   <= oen_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            regs_q  <= regs_d;
        end
    end

    always_comb begin
        o_rd_data = 9'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_rd_addr == 4'(i)) o_rd_data = regs_q[i];
        end
    end

    assign o_sda_oen   = oen_q;
    assign o_reg_wen   = wen_q;
    assign o_reg_addr  = addr_q;
    assign o_reg_data  = data_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_frame_err = err_q;

endmodule
